fetch_unit: RTL

Instruction fetch sequencer sitting directly downstream of the program counter. It reads the current PC value, issues a read request to program memory and latches the returned instruction. It presents the instruction to decode over a valid/ready handshake and pulses the PC increment strobe once per accepted fetch. It also detects the HALT opcode and flags memory-response timeouts.

---
 rtl/salamander_pkg.sv | 16 +
 rtl/fetch_unit.sv | 110 +++++++++++
 2 files changed

// File: rtl/salamander_pkg.sv
// rtl/salamander_pkg.sv - shared fetch types, default widths and the HALT opcode
package salamander_pkg;

    localparam int DEF_ADDR_W = 5;
    localparam int DEF_INSTR_W = 8;
    localparam logic [7:0] DEF_HALT_OPCODE = 8'hFF;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        HOLD,
        HALTED,
        ERROR
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch sequencer between the PC and decode
module fetch_unit
    import salamander_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INSTR_W = DEF_INSTR_W,
    parameter logic [INSTR_W-1:0] HALT_OPCODE = INSTR_W'(DEF_HALT_OPCODE),
    parameter int TIMEOUT = 15
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               en,
    input  logic [ADDR_W-1:0]  pc_val,
    output logic               pc_inc,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [ADDR_W-1:0]  instr_addr,
    output logic               halted,
    output logic               fetch_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);

    fetch_state_t state;
    fetch_state_t state_next;
    logic [CNT_W-1:0] wait_cnt;

    logic timed_out;
    logic handshake;

    assign timed_out = (state == FETCH) && !mem_ack && (wait_cnt == CNT_LIMIT);
    assign handshake = (state == HOLD) && instr_ready;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            instr_data <= '0;
            instr_addr <= '0;
            halted     <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            state <= state_next;
            // Counter idles at zero outside FETCH, so every fetch starts from a clean count
            if (state != FETCH) begin
                wait_cnt <= '0;
            end else if (!mem_ack && wait_cnt != CNT_LIMIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (state == FETCH && mem_ack) begin
                instr_data <= mem_rdata;
                instr_addr <= pc_val;
            end
            if (handshake && instr_data == HALT_OPCODE) begin
                halted <= 1'b1;
            end
            if (timed_out) begin
                fetch_err <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next  = state;
        mem_req     = 1'b0;
        mem_addr    = '0;
        pc_inc      = 1'b0;
        instr_valid = 1'b0;
        case (state)
            IDLE: begin
                if (en) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_val;
                if (mem_ack) begin
                    // The PC stays on a HALT so it still points at it afterwards
                    pc_inc     = (mem_rdata != HALT_OPCODE);
                    state_next = HOLD;
                end else if (timed_out) begin
                    state_next = ERROR;
                end
            end
            HOLD: begin
                instr_valid = 1'b1;
                if (handshake) begin
                    if (instr_data == HALT_OPCODE) begin
                        state_next = HALTED;
                    end else if (en) begin
                        state_next = FETCH;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            HALTED: state_next = HALTED;
            ERROR: state_next = ERROR;
            default: state_next = IDLE;
        endcase
    end

endmodule
